grf_write_arbiter: RTL

- Single-port write-side driver for the general register file (GRF).
- Merges two result sources onto the GRF write port (A3/WD/WrEn/PC4):
  - the in-order pipeline writeback stage, which can never stall;
  - the multi-cycle multiply/divide unit (MDU), which uses a valid/ready handshake.
- Buffers MDU results in a small FIFO and drains them only in cycles where the pipeline is not writing.
- Exports a pending-destination mask so decode can stall readers and writers of registers whose results are still buffered.

---
 rtl/grf_write_arbiter_pkg.sv | 22 ++
 rtl/grf_write_arbiter_if.sv | 41 ++++
 rtl/grf_wr_fifo.sv | 75 +++++++
 rtl/grf_write_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/grf_write_arbiter_pkg.sv
// Shared types and helpers for the GRF write-side arbiter.
// Holds the register-file geometry, the write-request record and the one-hot decode.
package grf_write_arbiter_pkg;

  localparam int GRF_AW   = 5;
  localparam int GRF_DW   = 32;
  localparam int GRF_NREG = 32;

  typedef struct packed {
    logic [GRF_AW-1:0] addr;
    logic [GRF_DW-1:0] data;
    logic [31:0]       pc4;
  } grf_wr_req_t;

  function automatic logic [GRF_NREG-1:0] grf_onehot(input logic [GRF_AW-1:0] a);
    logic [GRF_NREG-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/grf_write_arbiter_if.sv
// Bundle of pipeline/MDU request signals and GRF write-port outputs.
// The arbiter sits on the slave side; the producer/consumer environment on the master side.
interface grf_write_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic              pipe_we;
  logic [AW-1:0]     pipe_addr;
  logic [DW-1:0]     pipe_data;
  logic [31:0]       pipe_pc4;

  logic              mdu_valid;
  logic              mdu_ready;
  logic [AW-1:0]     mdu_addr;
  logic [DW-1:0]     mdu_data;
  logic [31:0]       mdu_pc4;

  logic [AW-1:0]     grf_a3;
  logic [DW-1:0]     grf_wd;
  logic              grf_wren;
  logic [31:0]       grf_pc4;

  logic [(2**AW)-1:0] pend_mask;
  logic              err;

  modport master (
    output pipe_we, pipe_addr, pipe_data, pipe_pc4,
    output mdu_valid, mdu_addr, mdu_data, mdu_pc4,
    input  mdu_ready,
    input  grf_a3, grf_wd, grf_wren, grf_pc4,
    input  pend_mask, err
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, pipe_pc4,
    input  mdu_valid, mdu_addr, mdu_data, mdu_pc4,
    output mdu_ready,
    output grf_a3, grf_wd, grf_wren, grf_pc4,
    output pend_mask, err
  );
endinterface

// File: rtl/grf_wr_fifo.sv
// Synchronous FIFO buffering MDU write requests until the GRF port is free.
// Exposes a per-entry valid/address view so the top can build the pending mask.
module grf_wr_fifo
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  grf_wr_req_t                   push_req,
  input  logic                          pop,
  output grf_wr_req_t                   head,
  output logic                          full,
  output logic [CW-1:0]                 count,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][GRF_AW-1:0]  ent_addr
);

  grf_wr_req_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_req;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] offs;
    offs      = '0;
    ent_valid = '0;
    ent_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs         = PW'(i) - rd_ptr_q;
      ent_valid[i] = (CW'(offs) < count_q);
      ent_addr[i]  = mem_q[i].addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// GRF write-port arbiter: pipeline writeback always wins, MDU results are
// buffered and drained into idle slots through a registered output stage.
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = GRF_DW,
  parameter int AW    = GRF_AW
) (
  input  logic              clk,
  input  logic              reset,
  grf_write_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  grf_wr_req_t                 out_req_q, out_req_d;
  logic                        out_wren_q, out_wren_d;
  logic                        out_mdu_q, out_mdu_d;
  logic                        err_q, err_d;
  logic                        stall_q, stall_d;

  grf_wr_req_t                 mdu_req, pipe_req, fifo_head;
  logic                        fifo_full, fifo_empty;
  logic [CW-1:0]               fifo_count;
  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0][GRF_AW-1:0] ent_addr;
  logic                        pipe_real, push, pop;
  logic [(2**AW)-1:0]          pend;

  always_comb begin
    mdu_req.addr  = bus.mdu_addr;
    mdu_req.data  = bus.mdu_data;
    mdu_req.pc4   = bus.mdu_pc4;
    pipe_req.addr = bus.pipe_addr;
    pipe_req.data = bus.pipe_data;
    pipe_req.pc4  = bus.pipe_pc4;
  end

  assign fifo_empty = (fifo_count == '0);
  assign pipe_real  = bus.pipe_we && (bus.pipe_addr != '0);
  // Writes to r0 complete the handshake but are never buffered.
  assign push       = bus.mdu_valid && !fifo_full && (bus.mdu_addr != '0);
  assign pop        = !pipe_real && !fifo_empty;

  grf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_req  (mdu_req),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .count     (fifo_count),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pend = pend | grf_onehot(ent_addr[i]);
    end
    if (out_wren_q && out_mdu_q) pend = pend | grf_onehot(out_req_q.addr);
  end

  always_comb begin
    out_req_d  = out_req_q;
    out_wren_d = 1'b0;
    out_mdu_d  = 1'b0;
    if (pipe_real) begin
      out_req_d  = pipe_req;
      out_wren_d = 1'b1;
    end else if (pop) begin
      out_req_d  = fifo_head;
      out_wren_d = 1'b1;
      out_mdu_d  = 1'b1;
    end
  end

  // stall_q remembers an offered-but-refused MDU result so a withdrawn offer is caught.
  always_comb begin
    stall_d = bus.mdu_valid && fifo_full;
    err_d   = err_q
            | (pipe_real && pend[bus.pipe_addr])
            | (stall_q && !bus.mdu_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_req_q  <= '0;
      out_wren_q <= 1'b0;
      out_mdu_q  <= 1'b0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      out_req_q  <= out_req_d;
      out_wren_q <= out_wren_d;
      out_mdu_q  <= out_mdu_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.mdu_ready = !fifo_full;
  assign bus.grf_a3    = out_req_q.addr;
  assign bus.grf_wd    = out_req_q.data;
  assign bus.grf_pc4   = out_req_q.pc4;
  assign bus.grf_wren  = out_wren_q;
  assign bus.pend_mask = pend;
  assign bus.err       = err_q;

endmodule
